// File: rtl/temp_scan_sequencer_if.sv
// Handshake between the scan sequencer and the TMP101 I2C read unit.
// The sequencer is the master: it issues StartRead/ChipSelect and consumes Done/ReadData.
interface temp_scan_sequencer_if;
    logic       StartRead;
    logic [2:0] ChipSelect;
    logic       Done;
    logic [7:0] ReadData;

    modport master (
        output StartRead,
        output ChipSelect,
        input  Done,
        input  ReadData
    );

    modport slave (
        input  StartRead,
        input  ChipSelect,
        output Done,
        output ReadData
    );
endinterface

// File: rtl/temp_scan_sequencer.sv
// Round-robin poller for up to 8 TMP101 sensors behind one I2C read unit.
// Optional feature macro: TEMP_SCAN_MINMAX_EN adds MaxTemp/MinTemp extreme tracking.
module temp_scan_sequencer #(
    parameter int NUM_SENSORS     = 4,
    parameter int INTERVAL_CYCLES = 75000000,
    parameter int TIMEOUT_CYCLES  = 1500000,
    parameter int CNT_WIDTH       = 30
) (
    input  logic                   clock,
    input  logic                   Reset,
    input  logic                   Enable,
    input  logic [2:0]             ViewSelect,
    temp_scan_sequencer_if.master  rd,
    output logic [7:0]             Temperature,
    output logic                   Valid,
    output logic [7:0]             ErrorFlags,
    output logic                   Busy,
`ifdef TEMP_SCAN_MINMAX_EN
    output logic [7:0]             MaxTemp,
    output logic [7:0]             MinTemp,
`endif
    output logic [7:0]             ScanCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ARM,
        S_WAIT_DONE,
        S_STORE,
        S_FAIL,
        S_NEXT,
        S_INTERVAL
    } state_t;

    // The ARM cycle already counted once, so the timeout fires on the edge
    // where the counter would reach TIMEOUT_CYCLES-1.
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 2);
    localparam logic [CNT_WIDTH-1:0] INTERVAL_LAST = CNT_WIDTH'(INTERVAL_CYCLES - 1);
    localparam logic [2:0]           LAST_IDX      = 3'(NUM_SENSORS - 1);
    localparam logic [3:0]           NUM_SEL       = 4'(NUM_SENSORS);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [2:0]             r_index;
    logic [7:0]             r_scan;
    logic [7:0]             r_regs [8];
    logic [7:0]             r_valid;
    logic [7:0]             r_err;
    logic [7:0]             r_temp;
    logic                   r_temp_valid;
    logic                   w_start;
    logic                   w_busy;
    logic                   w_view_in_range;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement leaves a signal unassigned and infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (Enable) begin
                    w_state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_start      = 1'b1;
                w_state_next = S_ARM;
            end
            S_ARM: begin
                if (!rd.Done) begin
                    w_state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (rd.Done) begin
                    w_state_next = S_STORE;
                end else if (r_cnt >= TIMEOUT_LAST) begin
                    w_state_next = S_FAIL;
                end
            end
            S_STORE, S_FAIL: begin
                w_state_next = S_NEXT;
            end
            S_NEXT: begin
                w_state_next = S_INTERVAL;
            end
            S_INTERVAL: begin
                if (r_cnt >= INTERVAL_LAST) begin
                    w_state_next = Enable ? S_LAUNCH : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // One counter serves both the read timeout and the inter-read interval.
    always_ff @(posedge clock) begin
        if (Reset) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_LAUNCH, S_NEXT:               r_cnt <= '0;
                S_ARM, S_WAIT_DONE, S_INTERVAL: r_cnt <= r_cnt + 1'b1;
                default:                        r_cnt <= r_cnt;
            endcase
        end
    end

    // NOTE: the per-sensor reading array is reset explicitly because a cleared
    // register file is part of the reset state; it is small enough to be flops.
    always_ff @(posedge clock) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
            r_valid <= '0;
            r_err   <= '0;
            r_index <= '0;
            r_scan  <= '0;
        end else begin
            case (r_state)
                S_STORE: begin
                    r_regs[r_index]  <= rd.ReadData;
                    r_valid[r_index] <= 1'b1;
                    r_err[r_index]   <= 1'b0;
                end
                S_FAIL: begin
                    r_valid[r_index] <= 1'b0;
                    r_err[r_index]   <= 1'b1;
                end
                S_NEXT: begin
                    if (r_index >= LAST_IDX) begin
                        r_index <= '0;
                        r_scan  <= r_scan + 8'd1;
                    end else begin
                        r_index <= r_index + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_view_in_range = ({1'b0, ViewSelect} < NUM_SEL);

    always_ff @(posedge clock) begin
        if (Reset) begin
            r_temp       <= '0;
            r_temp_valid <= 1'b0;
        end else begin
            r_temp       <= w_view_in_range ? r_regs[ViewSelect] : 8'h00;
            r_temp_valid <= w_view_in_range ? r_valid[ViewSelect] : 1'b0;
        end
    end

`ifdef TEMP_SCAN_MINMAX_EN
    logic [7:0] r_max;
    logic [7:0] r_min;
    logic       r_have_sample;

    // The first stored reading seeds both extremes; later ones compare signed.
    always_ff @(posedge clock) begin
        if (Reset) begin
            r_max         <= '0;
            r_min         <= '0;
            r_have_sample <= 1'b0;
        end else if (r_state == S_STORE) begin
            r_have_sample <= 1'b1;
            if (!r_have_sample || ($signed(rd.ReadData) > $signed(r_max))) begin
                r_max <= rd.ReadData;
            end
            if (!r_have_sample || ($signed(rd.ReadData) < $signed(r_min))) begin
                r_min <= rd.ReadData;
            end
        end
    end

    assign MaxTemp = r_max;
    assign MinTemp = r_min;
`endif

    assign rd.StartRead  = w_start;
    assign rd.ChipSelect = r_index;
    assign Busy          = w_busy;
    assign Temperature   = r_temp;
    assign Valid         = r_temp_valid;
    assign ErrorFlags    = r_err;
    assign ScanCount     = r_scan;

endmodule

// File: tb/tb_temp_scan_sequencer.sv
// Randomized bench for temp_scan_sequencer against a transaction-level scan model.
// Build with TEMP_SCAN_MINMAX_EN defined to also cover the min/max outputs.
module tb_temp_scan_sequencer;

    localparam int NS  = 3;
    localparam int INT = 10;
    localparam int TMO = 20;

    logic       clock;
    logic       Reset;
    logic       Enable;
    logic [2:0] ViewSelect;
    logic [7:0] Temperature;
    logic       Valid;
    logic [7:0] ErrorFlags;
    logic       Busy;
    logic [7:0] ScanCount;
`ifdef TEMP_SCAN_MINMAX_EN
    logic [7:0] MaxTemp;
    logic [7:0] MinTemp;
`endif

    temp_scan_sequencer_if rd ();

    temp_scan_sequencer #(
        .NUM_SENSORS    (NS),
        .INTERVAL_CYCLES(INT),
        .TIMEOUT_CYCLES (TMO),
        .CNT_WIDTH      (30)
    ) dut (
        .clock      (clock),
        .Reset      (Reset),
        .Enable     (Enable),
        .ViewSelect (ViewSelect),
        .rd         (rd),
        .Temperature(Temperature),
        .Valid      (Valid),
        .ErrorFlags (ErrorFlags),
        .Busy       (Busy),
`ifdef TEMP_SCAN_MINMAX_EN
        .MaxTemp    (MaxTemp),
        .MinTemp    (MinTemp),
`endif
        .ScanCount  (ScanCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int exp_start;

    // Reference model: what each sensor slot should hold after each read.
    logic [7:0] m_reg [8];
    bit         m_val [8];
    bit         m_err [8];
    int         m_idx;
    logic [7:0] m_scan;
    bit         m_have;
    logic [7:0] m_max;
    logic [7:0] m_min;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_reg[i] = 8'h00;
            m_val[i] = 1'b0;
            m_err[i] = 1'b0;
        end
        m_idx  = 0;
        m_scan = 8'h00;
        m_have = 1'b0;
        m_max  = 8'h00;
        m_min  = 8'h00;
    endtask

    function automatic logic [7:0] err_vec();
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i] = m_err[i];
        return v;
    endfunction

    function automatic logic [7:0] exp_temp(input logic [2:0] v);
        return (int'(v) < NS) ? m_reg[v] : 8'h00;
    endfunction

    function automatic bit exp_valid(input logic [2:0] v);
        return (int'(v) < NS) ? m_val[v] : 1'b0;
    endfunction

    task automatic check_view(input string tag);
        check({tag, "_temp"},  32'(Temperature), 32'(exp_temp(ViewSelect)));
        check({tag, "_valid"}, 32'(Valid),       32'(exp_valid(ViewSelect)));
    endtask

    task automatic check_minmax();
`ifdef TEMP_SCAN_MINMAX_EN
        check("max_temp", 32'(MaxTemp), 32'(m_max));
        check("min_temp", 32'(MinTemp), 32'(m_min));
`endif
    endtask

    // mode 0: answer after 5 clocks; 1: stale Done held across launch; 2: no answer.
    task automatic run_read(input int mode, input logic [7:0] data, input bit drop_en);
        bit         seen;
        int         t0;
        int         t_store;
        logic [7:0] old_err;
        seen = 1'b0;
        for (int n = 0; n < 80; n++) begin
            if (rd.StartRead) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("start_seen", 32'(seen), 32'd1);
        if (!seen) return;
        t0 = cyc;
        if (exp_start >= 0) check("start_cycle", 32'(cyc), 32'(exp_start));
        check("chip_select", 32'(rd.ChipSelect), 32'(m_idx));
        check("busy_launch", 32'(Busy), 32'd1);
        check("err_flags", 32'(ErrorFlags), 32'(err_vec()));
        check("scan_count", 32'(ScanCount), 32'(m_scan));
        check_view("view_launch");
        check_minmax();

        t_store = (mode == 0) ? 6 : (mode == 1) ? 7 : TMO;
        if (mode == 1) begin
            rd.Done     = 1'b1;
            rd.ReadData = 8'hEE;
        end
        ViewSelect = 3'($urandom_range(0, 7));
        old_err    = err_vec();
        for (int k = 1; k <= t_store + 2; k++) begin
            tick();
            if (k == 1) begin
                check_view("view_change");
                check("start_pulse_1cyc", 32'(rd.StartRead), 32'd0);
            end
            if (drop_en && k == 3) Enable = 1'b0;
            case (mode)
                0: begin
                    if (k == 5) begin
                        rd.Done     = 1'b1;
                        rd.ReadData = data;
                    end
                    if (k == 7) rd.Done = 1'b0;
                end
                1: begin
                    if (k == 3) rd.Done = 1'b0;
                    if (k == 6) begin
                        rd.Done     = 1'b1;
                        rd.ReadData = data;
                    end
                    if (k == 8) rd.Done = 1'b0;
                end
                default: begin
                    if (k == TMO)     check("err_before_fail", 32'(ErrorFlags), 32'(old_err));
                    if (k == TMO + 1) check("err_after_fail", 32'(ErrorFlags[m_idx]), 32'd1);
                end
            endcase
        end

        if (mode != 2) begin
            m_reg[m_idx] = data;
            m_val[m_idx] = 1'b1;
            m_err[m_idx] = 1'b0;
            if (!m_have || $signed(data) > $signed(m_max)) m_max = data;
            if (!m_have || $signed(data) < $signed(m_min)) m_min = data;
            m_have = 1'b1;
        end else begin
            m_val[m_idx] = 1'b0;
            m_err[m_idx] = 1'b1;
        end
        if (m_idx == NS - 1) begin
            m_idx  = 0;
            m_scan = m_scan + 8'd1;
        end else begin
            m_idx = m_idx + 1;
        end
        check("scan_after_next", 32'(ScanCount), 32'(m_scan));
        check("err_after_read", 32'(ErrorFlags), 32'(err_vec()));
        check("busy_interval", 32'(Busy), 32'd1);
        exp_start = t0 + t_store + INT + 2;

        if (drop_en) begin
            while (cyc < t0 + t_store + INT + 1) tick();
            check("busy_last_interval", 32'(Busy), 32'd1);
            tick();
            check("busy_idle", 32'(Busy), 32'd0);
            check("no_start_idle", 32'(rd.StartRead), 32'd0);
            exp_start = -1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts;
        bit seen;
        Reset       = 1'b1;
        Enable      = 1'b0;
        ViewSelect  = 3'd0;
        rd.Done     = 1'b0;
        rd.ReadData = 8'h00;
        exp_start   = -1;
        model_reset();
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        check("rst_start", 32'(rd.StartRead), 32'd0);
        check("rst_cs", 32'(rd.ChipSelect), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_scan", 32'(ScanCount), 32'd0);
        check("rst_err", 32'(ErrorFlags), 32'd0);
        check_view("rst_view");
        check_minmax();

        // First scan with the fixed readings, then view sensor 1.
        Enable    = 1'b1;
        exp_start = cyc + 1;
        run_read(0, 8'h19, 1'b0);
        run_read(0, 8'h1A, 1'b0);
        run_read(0, 8'h1B, 1'b0);
        check("scan_one", 32'(ScanCount), 32'd1);
        ViewSelect = 3'd1;
        tick();
        check("view1_temp", 32'(Temperature), 32'h1A);
        check("view1_valid", 32'(Valid), 32'd1);

        // Stale Done on sensor 0, timeout on sensor 2, then a good read clears it.
        run_read(1, 8'h21, 1'b0);
        run_read(0, 8'h22, 1'b0);
        run_read(2, 8'h00, 1'b0);
        check("err_sensor2", 32'(ErrorFlags), 32'h04);
        run_read(0, 8'h23, 1'b0);
        run_read(0, 8'h24, 1'b0);
        run_read(0, 8'h25, 1'b0);
        check("err_cleared", 32'(ErrorFlags), 32'h00);

        for (int r = 0; r < 24; r++) begin
            int roll;
            roll = $urandom_range(0, 9);
            run_read((roll < 6) ? 0 : (roll < 8) ? 1 : 2, 8'($urandom), 1'b0);
        end

        // Drop Enable during a read of sensor 1.
        while (m_idx != 1) run_read(0, 8'($urandom), 1'b0);
        run_read(0, 8'h5A, 1'b1);
        starts = 0;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (rd.StartRead) starts++;
        end
        check("no_start_after_stop", 32'(starts), 32'd0);
        check("busy_stopped", 32'(Busy), 32'd0);
        ViewSelect = 3'd1;
        tick();
        check("stopped_reg1", 32'(Temperature), 32'h5A);

        // Reset while the FSM sits in ARM.
        Enable = 1'b1;
        seen   = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (rd.StartRead) begin
                seen = 1'b1;
                break;
            end
        end
        check("restart_seen", 32'(seen), 32'd1);
        tick();
        Reset  = 1'b1;
        Enable = 1'b0;
        tick();
        model_reset();
        check("arm_rst_start", 32'(rd.StartRead), 32'd0);
        check("arm_rst_cs", 32'(rd.ChipSelect), 32'd0);
        check("arm_rst_busy", 32'(Busy), 32'd0);
        check("arm_rst_scan", 32'(ScanCount), 32'd0);
        check("arm_rst_err", 32'(ErrorFlags), 32'd0);
        check_view("arm_rst_view");
        check_minmax();
        Reset      = 1'b0;
        ViewSelect = 3'd5;
        tick();
        check("view5_temp", 32'(Temperature), 32'd0);
        check("view5_valid", 32'(Valid), 32'd0);

        // Signed extremes after reset.
        Enable    = 1'b1;
        exp_start = cyc + 1;
        run_read(0, 8'h19, 1'b0);
        run_read(0, 8'hFB, 1'b0);
        run_read(0, 8'h1E, 1'b0);
`ifdef TEMP_SCAN_MINMAX_EN
        check("max_final", 32'(MaxTemp), 32'h1E);
        check("min_final", 32'(MinTemp), 32'hFB);
`endif
        check("scan_final", 32'(ScanCount), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
